// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one sync_fifo write port among NUM_REQ producers.
// Grants bursts of up to MAX_BURST beats, back-pressured by the FIFO full flag.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic                          busy
);

    localparam int CNT_WIDTH = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [NUM_REQ-1:0]    grant_r;
    logic [ID_WIDTH-1:0]   grant_id_r;
    logic [ID_WIDTH-1:0]   ptr_r;
    logic [CNT_WIDTH-1:0]  count_r;
    logic                  gap_r;
    logic                  xfer_s;
    logic                  release_s;
    logic                  win_found_s;
    logic [ID_WIDTH-1:0]   win_id_s;
    logic [ID_WIDTH-1:0]   next_ptr_s;
    logic [ID_WIDTH-1:0]   search_ptr_s;
    logic [NUM_REQ-1:0]    win_onehot_s;

    // Lowest index at or after start (with wrap) whose valid is high; MSB flags a hit.
    function automatic logic [ID_WIDTH:0] rr_search(input logic [NUM_REQ-1:0] v,
                                                    input logic [ID_WIDTH-1:0] start);
        logic [ID_WIDTH:0]   res;
        logic [ID_WIDTH-1:0] idx;
        res = {(ID_WIDTH+1){1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_WIDTH'((int'(start) + k) % NUM_REQ);
            if (v[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Search pointer: the stored pointer when idle, the post-release pointer when granting.
    always_comb begin
        next_ptr_s = (grant_id_r == ID_WIDTH'(NUM_REQ - 1)) ? {ID_WIDTH{1'b0}}
                                                           : grant_id_r + ID_WIDTH'(1);
        if (state_r == GRANT) begin
            search_ptr_s = next_ptr_s;
        end else begin
            search_ptr_s = ptr_r;
        end
        {win_found_s, win_id_s} = rr_search(req_valid, search_ptr_s);
        win_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id_s;
    end

    // Zero-latency write datapath; gap_r marks the bubble cycle after a re-grant.
    always_comb begin
        req_ready    = {NUM_REQ{1'b0}};
        xfer_s       = 1'b0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = {DATA_WIDTH{1'b0}};
        release_s    = 1'b0;
        if (state_r == GRANT && !gap_r) begin
            if (!fifo_full) begin
                req_ready = grant_r;
                xfer_s    = req_valid[grant_id_r];
            end else begin
                req_ready = {NUM_REQ{1'b0}};
                xfer_s    = 1'b0;
            end
            release_s = !req_valid[grant_id_r] ||
                        (xfer_s && (count_r == CNT_WIDTH'(MAX_BURST - 1)));
        end else begin
            release_s = 1'b0;
        end
        if (xfer_s) begin
            fifo_wr_en   = 1'b1;
            fifo_wr_data = req_data[grant_id_r*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            fifo_wr_en   = 1'b0;
            fifo_wr_data = {DATA_WIDTH{1'b0}};
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = (|req_valid) ? GRANT : IDLE;
            GRANT:   state_nxt_s = (release_s && !win_found_s) ? IDLE : GRANT;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Grant, pointer, beat count and bubble flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_r    <= {NUM_REQ{1'b0}};
            grant_id_r <= {ID_WIDTH{1'b0}};
            ptr_r      <= {ID_WIDTH{1'b0}};
            count_r    <= {CNT_WIDTH{1'b0}};
            gap_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (win_found_s) begin
                        grant_r    <= win_onehot_s;
                        grant_id_r <= win_id_s;
                        count_r    <= {CNT_WIDTH{1'b0}};
                        gap_r      <= 1'b0;
                    end
                end
                GRANT: begin
                    if (release_s) begin
                        ptr_r   <= next_ptr_s;
                        count_r <= {CNT_WIDTH{1'b0}};
                        if (win_found_s) begin
                            grant_r    <= win_onehot_s;
                            grant_id_r <= win_id_s;
                            gap_r      <= 1'b1;
                        end else begin
                            grant_r <= {NUM_REQ{1'b0}};
                            gap_r   <= 1'b0;
                        end
                    end else if (gap_r) begin
                        gap_r <= 1'b0;
                    end else if (xfer_s) begin
                        count_r <= count_r + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    grant_r <= {NUM_REQ{1'b0}};
                    gap_r   <= 1'b0;
                end
            endcase
        end
    end

    assign grant    = grant_r;
    assign grant_id = grant_id_r;
    assign busy     = (state_r == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed corner sequences and
// randomized traffic against a behavioural round-robin model with a queue-based FIFO.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int MB    = 4;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [DW-1:0] pdata [N];
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          fifo_full;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_wr_data;
    logic [N-1:0]  grant;
    logic [1:0]    grant_id;
    logic          busy;

    assign req_data = {pdata[3], pdata[2], pdata[1], pdata[0]};

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data), .grant(grant), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: owner -1 means nobody holds the write port.
    int m_owner, m_id, m_beats, m_ptr;
    bit m_gap;

    logic [DW-1:0] q[$];
    int  seq [N];
    bit  auto_data, force_full;
    bit  push_pend;
    logic [DW-1:0] push_val;
    logic [N-1:0]  acc_mask;

    typedef struct {
        logic [N-1:0]  valid;
        logic [DW-1:0] d0;
        logic          full;
        logic [N-1:0]  g;
        logic          wr;
        logic [DW-1:0] wd;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int search(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_id = 0; m_beats = 0; m_ptr = 0; m_gap = 1'b0;
    endtask

    task automatic refresh();
        fifo_full = force_full || (q.size() >= DEPTH);
    endtask

    // Compare DUT against the model for this cycle, then advance the model by one edge.
    task automatic model_step();
        logic [N-1:0]  one, exp_g, exp_rdy;
        logic [DW-1:0] exp_d;
        bit xfer;
        int w;
        one     = 4'b0001;
        exp_g   = (m_owner >= 0) ? (one << m_owner) : 4'b0000;
        exp_rdy = (m_owner >= 0 && !m_gap && !fifo_full) ? exp_g : 4'b0000;
        xfer    = (exp_rdy != 4'b0000) && req_valid[m_owner];
        exp_d   = xfer ? pdata[m_owner] : 8'h00;
        chk("grant", grant, exp_g);
        chk("grant_id", grant_id, m_id);
        chk("busy", busy, m_owner >= 0);
        chk("req_ready", req_ready, exp_rdy);
        chk("wr_en", fifo_wr_en, xfer);
        chk("wr_data", fifo_wr_data, exp_d);
        chk("overflow", fifo_wr_en & fifo_full, 1'b0);
        push_pend = fifo_wr_en;
        push_val  = fifo_wr_data;
        acc_mask  = req_valid & req_ready;
        if (m_owner < 0) begin
            w = search(req_valid, m_ptr);
            if (w >= 0) begin m_owner = w; m_id = w; m_beats = 0; m_gap = 1'b0; end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else begin
            if (xfer) m_beats++;
            if (!req_valid[m_owner] || m_beats == MB) begin
                m_ptr = (m_owner + 1) % N;
                w = search(req_valid, m_ptr);
                if (w >= 0) begin m_owner = w; m_id = w; m_beats = 0; m_gap = 1'b1; end
                else m_owner = -1;
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_step();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (push_pend && q.size() < DEPTH) q.push_back(push_val);
        for (int i = 0; i < N; i++) begin
            if (acc_mask[i]) seq[i]++;
            if (auto_data) pdata[i] = {2'(i), 6'(seq[i])};
        end
        refresh();
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = 4'b0000; force_full = 1'b0; auto_data = 1'b0;
        q.delete();
        for (int i = 0; i < N; i++) begin seq[i] = 0; pdata[i] = 8'h00; end
        refresh();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic pop_chk(input string name, input logic [DW-1:0] exp);
        if (q.size() == 0) chk({name, "_empty"}, 32'd0, 32'd1);
        else chk(name, q.pop_front(), exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'b0001, 8'h10, 1'b0, 4'b0000, 1'b0, 8'h00};
        tbl[1] = '{4'b0001, 8'h10, 1'b0, 4'b0001, 1'b1, 8'h10};
        tbl[2] = '{4'b0001, 8'h11, 1'b0, 4'b0001, 1'b1, 8'h11};
        tbl[3] = '{4'b0001, 8'h12, 1'b0, 4'b0001, 1'b1, 8'h12};
        tbl[4] = '{4'b0001, 8'h13, 1'b0, 4'b0001, 1'b1, 8'h13};
        tbl[5] = '{4'b0001, 8'h14, 1'b0, 4'b0001, 1'b0, 8'h00};
        tbl[6] = '{4'b0001, 8'h14, 1'b0, 4'b0001, 1'b1, 8'h14};
        tbl[7] = '{4'b0001, 8'h15, 1'b0, 4'b0001, 1'b1, 8'h15};
        tbl[8] = '{4'b0000, 8'h00, 1'b0, 4'b0001, 1'b0, 8'h00};
        tbl[9] = '{4'b0000, 8'h00, 1'b0, 4'b0000, 1'b0, 8'h00};

        model_reset();
        do_reset();
        chk("rst_grant", grant, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr_en", fifo_wr_en, 1'b0);

        // Single producer, 6 beats: burst of 4, bubble, re-grant, 2 beats, release to idle.
        for (int i = 0; i < 10; i++) begin
            req_valid = tbl[i].valid; pdata[0] = tbl[i].d0; force_full = tbl[i].full;
            refresh();
            sample();
            chk($sformatf("tbl%0d_grant", i), grant, tbl[i].g);
            chk($sformatf("tbl%0d_wr_en", i), fifo_wr_en, tbl[i].wr);
            chk($sformatf("tbl%0d_wr_data", i), fifo_wr_data, tbl[i].wd);
            advance();
        end
        for (int i = 0; i < 6; i++) pop_chk("single_fifo", 8'h10 + 8'(i));

        // Full contention: bursts of 4 in order 0,1,2,3 then back to 0.
        do_reset();
        auto_data = 1'b1; req_valid = 4'b1111;
        for (int i = 0; i < N; i++) pdata[i] = {2'(i), 6'd0};
        repeat (22) tick();
        for (int k = 0; k < 16; k++) pop_chk("rr_order", {2'(k / 4), 6'(k % 4)});
        pop_chk("rr_wrap", {2'd0, 6'd4});

        // FIFO full for 5 cycles after beat 2 of a burst.
        do_reset();
        auto_data = 1'b1; req_valid = 4'b0100; pdata[2] = {2'd2, 6'd0};
        repeat (3) tick();
        force_full = 1'b1; refresh();
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("stall_ready", req_ready, 4'b0000);
            chk("stall_wr_en", fifo_wr_en, 1'b0);
            chk("stall_grant", grant, 4'b0100);
            advance();
        end
        force_full = 1'b0; refresh();
        repeat (2) tick();
        sample();
        chk("stall_bubble_wr_en", fifo_wr_en, 1'b0);
        advance();
        for (int k = 0; k < 4; k++) pop_chk("stall_fifo", {2'd2, 6'(k)});

        // Producer 1 drops valid mid-burst while producer 2 waits.
        do_reset();
        auto_data = 1'b1; req_valid = 4'b0110;
        for (int i = 0; i < N; i++) pdata[i] = {2'(i), 6'd0};
        repeat (3) tick();
        req_valid = 4'b0100;
        sample();
        chk("drop_wr_en", fifo_wr_en, 1'b0);
        chk("drop_grant", grant, 4'b0010);
        advance();
        req_valid = 4'b0110;
        sample();
        chk("drop_next_grant", grant, 4'b0100);
        advance();
        repeat (10) tick();

        // Asynchronous reset in the middle of a burst from producer 3.
        do_reset();
        auto_data = 1'b1; req_valid = 4'b1000; pdata[3] = {2'd3, 6'd0};
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("arst_grant", grant, 4'b0000);
        chk("arst_wr_en", fifo_wr_en, 1'b0);
        chk("arst_ready", req_ready, 4'b0000);
        chk("arst_busy", busy, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1; req_valid = 4'b1001;
        tick();
        sample();
        chk("arst_first_winner", grant, 4'b0001);
        advance();

        // 34 beats from one producer into a 32-deep FIFO with no reads.
        do_reset();
        auto_data = 1'b1; pdata[0] = 8'h00;
        for (int i = 0; i < 45; i++) begin
            req_valid[0] = (seq[0] < 34);
            tick();
        end
        chk("fill_count", q.size(), DEPTH);
        req_valid[0] = 1'b1;
        sample();
        chk("fill_ready_low", req_ready, 4'b0000);
        advance();
        void'(q.pop_front());
        void'(q.pop_front());
        refresh();
        for (int i = 0; i < 20 && seq[0] < 34; i++) begin
            req_valid[0] = (seq[0] < 34);
            tick();
        end
        chk("fill_rest_accepted", seq[0], 34);
        chk("fill_final_count", q.size(), DEPTH);

        // Randomized traffic with random full pressure and reads.
        do_reset();
        auto_data = 1'b1;
        for (int i = 0; i < N; i++) pdata[i] = {2'(i), 6'd0};
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i]) req_valid[i] = ($urandom_range(99) >= 10);
                else              req_valid[i] = ($urandom_range(99) < 40);
            end
            force_full = ($urandom_range(4) == 0);
            if (q.size() > 0 && $urandom_range(99) < 60) void'(q.pop_front());
            refresh();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares the write port of one sync_fifo among NUM_REQ producers.
- Each producer has a valid/ready handshake.
- The winner holds the grant for a burst of up to MAX_BURST beats, then rotates.
- Back-pressure comes from the FIFO full flag, so the FIFO never sees a write while full (overflow never asserts).
- Sits directly in front of sync_fifo wr_en/wr_data/full.

Parameters:
- NUM_REQ, 4, number of producers (>= 2)
- DATA_WIDTH, 8, data width; must match the FIFO
- MAX_BURST, 4, maximum beats per grant before forced rotation (>= 1)
- ID_WIDTH, $clog2(NUM_REQ), width of grant_id

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  producer i has data
- req_data  input  NUM_REQ*DATA_WIDTH  producer i data in slice [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  output  NUM_REQ  beat from producer i accepted this cycle when valid & ready
- fifo_full  input  1  sync_fifo full flag
- fifo_wr_en  output  1  to sync_fifo wr_en
- fifo_wr_data  output  DATA_WIDTH  to sync_fifo wr_data
- grant  output  NUM_REQ  registered one-hot grant (all-zero when idle)
- grant_id  output  ID_WIDTH  index of the current/last winner
- busy  output  1  high while in GRANT

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state = IDLE
  - grant = 0, grant_id = 0, busy = 0
  - rr pointer = 0, beat count = 0
  - req_ready = 0, fifo_wr_en = 0, fifo_wr_data = 0
- State machine, registered: IDLE, GRANT.
- Round-robin search: searches from the rr pointer upward with wrap. Lowest index at or after the pointer with req_valid high wins.
- IDLE:
  - If any req_valid is high, the next state is GRANT.
  - grant is set to the one-hot of the winner, grant_id to its index, and count is cleared.
  - No beat is accepted in the cycle the request is first seen. First-beat latency is 1 cycle.
- GRANT, combinational datapath (zero latency):
  - req_ready[i] = grant[i] & ~fifo_full.
  - xfer = req_valid[g] & req_ready[g].
  - fifo_wr_en = xfer.
  - fifo_wr_data = req_data slice g when xfer, else 0.
- GRANT, per-cycle sequencing:
  - On xfer, count increments.
  - If fifo_full is high with valid high: no transfer, count holds, grant holds indefinitely.
  - Release when xfer occurs with count == MAX_BURST-1 (burst done).
  - Release when req_valid[g] is low (producer idle). A low-valid cycle moves no data.
- Release:
  - rr pointer = (g+1) mod NUM_REQ.
  - Same edge, re-arbitrate using the new pointer and current req_valid.
  - If a winner exists: stay in GRANT with the new one-hot and count = 0. The new winner may be the same producer if it is the only one requesting. There is a 1-cycle bubble between bursts.
  - If no winner: go to IDLE, grant = 0, grant_id keeps its last value.
- Burst rule: a producer never gets more than MAX_BURST consecutive beats while any other producer is requesting. Under full contention, worst-case wait is (NUM_REQ-1)*(MAX_BURST+1) accepted-beat cycles, excluding full stalls.
- Width rules: count is $clog2(MAX_BURST+1) bits; the pointer is ID_WIDTH bits and wraps at NUM_REQ, not at 2^ID_WIDTH.
- req_valid[i] for a non-granted producer has no effect until it wins. Producers must hold data stable while valid & ~ready.
- Reset mid-burst: all outputs drop asynchronously; the next grant searches from index 0. Beats already written stay in the FIFO.
- fifo_wr_en is never high while fifo_full is high.

Test Plan:
- Only req0 valid with 6 beats 0x10..0x15, MAX_BURST=4 -> grant=0001 one cycle after valid; 0x10-0x13 written on consecutive cycles; 1-cycle bubble; re-grant to 0; 0x14,0x15 written; FIFO reads back 0x10..0x15.
- All 4 valid continuously, producer i sending 0xi0,0xi1,... -> grant order 0,1,2,3,0; 4 beats each; FIFO order 0x00-0x03, 0x10-0x13, 0x20-0x23, 0x30-0x33, 0x04...
- fifo_full forced high after beat 2 of a burst for 5 cycles -> req_ready=0, fifo_wr_en=0, grant held, count=2 held; beats 3-4 written after full drops.
- req1 drops valid after 2 beats while req2 valid -> release on the low-valid cycle; grant=0100 next cycle; req1's burst not resumed until its next turn.
- rst_n low mid-burst of req3 -> grant=0, fifo_wr_en=0 immediately; after release with req0 and req3 valid, req0 wins first.
- Single producer writes 34 beats into DEPTH=32 FIFO with no reads -> exactly 32 writes; req_ready low once full; FIFO overflow never asserts; 2 remaining beats accepted after 2 reads.
